mem_wb_pipe_reg: RTL

Parametrised MEM→WB pipeline register that carries the complete memory-stage bundle: PC, write-back enable, memory-read enable, ALU result, load data, and destination register. It adds per-entry valid tracking, freeze (stall) and flush control, a configurable number of retiming stages, and a saturating stall counter for performance monitoring. It sits between the MEM stage and the WB stage of the core.

---
 rtl/mem_wb_pipe_reg.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: STAGES-deep chain of memory-stage bundles with
// per-entry valid, freeze/flush control and a saturating frozen-cycle counter.
module mem_wb_pipe_reg #(
  parameter int WORD_W = 32,
  parameter int DEST_W = 4,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Freeze,
  input  logic              Flush,
  input  logic              Valid_In,
  input  logic [WORD_W-1:0] PC_In,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic [WORD_W-1:0] ALU_Res_In,
  input  logic [WORD_W-1:0] Data_In,
  input  logic [DEST_W-1:0] Dest_In,
  output logic              Valid_Out,
  output logic [WORD_W-1:0] PC_Out,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic [WORD_W-1:0] ALU_Res_Out,
  output logic [WORD_W-1:0] Data_Out,
  output logic [DEST_W-1:0] Dest_Out,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] pc;
    logic              wb_en;
    logic              mem_r_en;
    logic [WORD_W-1:0] alu_res;
    logic [WORD_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } stage_t;

  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  stage_t            in_bundle;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  // An invalid bundle must never carry a live write-back or load enable.
  always_comb begin
    in_bundle.valid    = Valid_In;
    in_bundle.pc       = PC_In;
    in_bundle.wb_en    = WB_EN_In & Valid_In;
    in_bundle.mem_r_en = MEM_R_EN_In & Valid_In;
    in_bundle.alu_res  = ALU_Res_In;
    in_bundle.data     = Data_In;
    in_bundle.dest     = Dest_In;
  end

  always_comb begin
    // NOTE: every path assigns stage_d first, so no latch can be inferred.
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (Flush) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_d[k] = '0;
      end
    end else if (!Freeze) begin
      stage_d[0] = in_bundle;
      for (int k = 1; k < STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!Flush && Freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value on the same edge; the whole chain is reset, not just valids,
  // because the outputs must read all-zero after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Valid_Out    = stage_q[STAGES-1].valid;
  assign PC_Out       = stage_q[STAGES-1].pc;
  assign WB_EN_Out    = stage_q[STAGES-1].wb_en;
  assign MEM_R_EN_Out = stage_q[STAGES-1].mem_r_en;
  assign ALU_Res_Out  = stage_q[STAGES-1].alu_res;
  assign Data_Out     = stage_q[STAGES-1].data;
  assign Dest_Out     = stage_q[STAGES-1].dest;
  assign Stall_Cnt    = stall_cnt_q;

endmodule
